// File: rtl/geofence_pkg.sv
// Shared geofence definitions: coordinate width, packed point type,
// signed cross-product width and the arbiter state encoding.
package geofence_pkg;

  localparam int COORD_W = 10;
  localparam int XPROD_W = 2 * COORD_W + 3;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } point_t;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  // Round-robin successor that also works when the requester count is not a power of two.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/cross_product_core.sv
// Combinational signed cross product (A-R)x(B-R) on unsigned {x,y} points.
// The product and subtract halves are exposed separately so the top can register between them.
module cross_product_core #(
  parameter int COORD_W = 10
) (
  input  logic        [2*COORD_W-1:0] pt_ref,
  input  logic        [2*COORD_W-1:0] pt_a,
  input  logic        [2*COORD_W-1:0] pt_b,
  output logic signed [2*COORD_W+1:0] prod_l,
  output logic signed [2*COORD_W+1:0] prod_r,
  input  logic signed [2*COORD_W+1:0] sub_l,
  input  logic signed [2*COORD_W+1:0] sub_r,
  output logic signed [2*COORD_W+2:0] result,
  output logic                        ge0
);

  localparam int DW = COORD_W + 1;
  localparam int PW = 2 * COORD_W + 2;
  localparam int RW = 2 * COORD_W + 3;

  logic signed [DW-1:0] dax;
  logic signed [DW-1:0] day;
  logic signed [DW-1:0] dbx;
  logic signed [DW-1:0] dby;

  // Zero-extend the unsigned coordinates so every difference is exact in COORD_W+1 signed bits.
  assign dax = $signed({1'b0, pt_a[2*COORD_W-1:COORD_W]}) - $signed({1'b0, pt_ref[2*COORD_W-1:COORD_W]});
  assign day = $signed({1'b0, pt_a[COORD_W-1:0]})         - $signed({1'b0, pt_ref[COORD_W-1:0]});
  assign dbx = $signed({1'b0, pt_b[2*COORD_W-1:COORD_W]}) - $signed({1'b0, pt_ref[2*COORD_W-1:COORD_W]});
  assign dby = $signed({1'b0, pt_b[COORD_W-1:0]})         - $signed({1'b0, pt_ref[COORD_W-1:0]});

  assign prod_l = PW'(dax) * PW'(dby);
  assign prod_r = PW'(dbx) * PW'(day);

  assign result = RW'(sub_l) - RW'(sub_r);
  assign ge0    = ~result[RW-1];

endmodule

// File: rtl/cross_product_arbiter.sv
// Round-robin arbiter with optional lock sharing one cross-product datapath.
// Define CROSS_ARB_PIPE_EN to register between the multipliers and the subtract stage.
module cross_product_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int COORD_W = geofence_pkg::COORD_W
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ-1:0]               req_lock,
  input  logic [NUM_REQ*2*COORD_W-1:0]     req_ref,
  input  logic [NUM_REQ*2*COORD_W-1:0]     req_p1,
  input  logic [NUM_REQ*2*COORD_W-1:0]     req_p2,
  output logic [NUM_REQ-1:0]               req_ready,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0]       rsp_id,
  output logic signed [2*COORD_W+2:0]      rsp_result,
  output logic                             rsp_ge0
);

  import geofence_pkg::*;

  localparam int ID_W = $clog2(NUM_REQ);
  localparam int PT_W = 2 * COORD_W;
  localparam int PW   = 2 * COORD_W + 2;
  localparam int RW   = 2 * COORD_W + 3;

  arb_state_t state;
  arb_state_t state_next;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] rr_ptr_next;
  logic [ID_W-1:0] owner;
  logic [ID_W-1:0] owner_next;

  logic [ID_W-1:0] grant_idx;
  logic [ID_W-1:0] cand;
  logic            grant_found;
  logic            hs;
  logic            in_adv;
  logic            out_adv;

  logic [PT_W-1:0] sel_ref;
  logic [PT_W-1:0] sel_a;
  logic [PT_W-1:0] sel_b;

  logic signed [PW-1:0] prod_l;
  logic signed [PW-1:0] prod_r;
  logic signed [PW-1:0] sub_l;
  logic signed [PW-1:0] sub_r;
  logic signed [RW-1:0] calc_result;
  logic                 calc_ge0;

  logic            load_valid;
  logic [ID_W-1:0] load_id;

  // Descending scan so the lowest offset from rr_ptr is the one left standing.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    if (state == LOCKED) begin
      grant_found = req_valid[owner];
      grant_idx   = owner;
    end else begin
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
        cand = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
        if (req_valid[cand]) begin
          grant_found = 1'b1;
          grant_idx   = cand;
        end
      end
    end
  end

  assign hs = grant_found && in_adv && !reset;

  always_comb begin
    req_ready = '0;
    if (hs) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    state_next  = state;
    rr_ptr_next = rr_ptr;
    owner_next  = owner;
    case (state)
      IDLE: begin
        if (hs) begin
          if (req_lock[grant_idx]) begin
            owner_next = grant_idx;
            state_next = LOCKED;
          end else begin
            rr_ptr_next = ID_W'(wrap_inc(int'(grant_idx), NUM_REQ));
          end
        end
      end
      LOCKED: begin
        if (hs && !req_lock[owner]) begin
          state_next  = IDLE;
          rr_ptr_next = ID_W'(wrap_inc(int'(owner), NUM_REQ));
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      rr_ptr <= '0;
      owner  <= '0;
    end else begin
      state  <= state_next;
      rr_ptr <= rr_ptr_next;
      owner  <= owner_next;
    end
  end

  assign sel_ref = req_ref[int'(grant_idx)*PT_W +: PT_W];
  assign sel_a   = req_p1[int'(grant_idx)*PT_W +: PT_W];
  assign sel_b   = req_p2[int'(grant_idx)*PT_W +: PT_W];

  cross_product_core #(
    .COORD_W(COORD_W)
  ) u_core (
    .pt_ref(sel_ref),
    .pt_a  (sel_a),
    .pt_b  (sel_b),
    .prod_l(prod_l),
    .prod_r(prod_r),
    .sub_l (sub_l),
    .sub_r (sub_r),
    .result(calc_result),
    .ge0   (calc_ge0)
  );

  assign out_adv = !rsp_valid || rsp_ready;

`ifdef CROSS_ARB_PIPE_EN
  logic            s1_valid;
  logic [ID_W-1:0] s1_id;
  logic signed [PW-1:0] s1_prod_l;
  logic signed [PW-1:0] s1_prod_r;

  // An empty product stage keeps accepting even while the response stage is stalled.
  assign in_adv = !s1_valid || out_adv;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s1_id     <= '0;
      s1_prod_l <= '0;
      s1_prod_r <= '0;
    end else if (in_adv) begin
      s1_valid  <= hs;
      s1_id     <= grant_idx;
      s1_prod_l <= prod_l;
      s1_prod_r <= prod_r;
    end
  end

  assign sub_l      = s1_prod_l;
  assign sub_r      = s1_prod_r;
  assign load_valid = s1_valid;
  assign load_id    = s1_id;
`else
  assign in_adv     = out_adv;
  assign sub_l      = prod_l;
  assign sub_r      = prod_r;
  assign load_valid = hs;
  assign load_id    = grant_idx;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_result <= '0;
      rsp_ge0    <= 1'b0;
    end else if (out_adv) begin
      rsp_valid <= load_valid;
      if (load_valid) begin
        rsp_id     <= load_id;
        rsp_result <= calc_result;
        rsp_ge0    <= calc_ge0;
      end
    end
  end

endmodule

// File: tb/tb_cross_product_arbiter.sv
// Scoreboard bench for cross_product_arbiter: directed grants, hand-checked vectors,
// stall hold, lock ownership and mid-run reset.
module tb_cross_product_arbiter;

  import geofence_pkg::*;

  localparam int N    = 4;
  localparam int CW   = 10;
  localparam int PT_W = 2 * CW;
  localparam int RW   = 2 * CW + 3;
`ifdef CROSS_ARB_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct packed {
    logic [1:0]           id;
    logic signed [RW-1:0] res;
    logic                 ge0;
  } exp_t;

  logic                  clk;
  logic                  reset;
  logic [N-1:0]          req_valid;
  logic [N-1:0]          req_lock;
  logic [N*PT_W-1:0]     req_ref;
  logic [N*PT_W-1:0]     req_p1;
  logic [N*PT_W-1:0]     req_p2;
  logic [N-1:0]          req_ready;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [1:0]            rsp_id;
  logic signed [RW-1:0]  rsp_result;
  logic                  rsp_ge0;

  exp_t                 exp_q[$];
  point_t               op_r[N];
  point_t               op_a[N];
  point_t               op_b[N];
  logic signed [RW-1:0] op_res[N];
  int                   op_seq = 0;
  int                   n_cmp  = 0;
  int                   n_fail = 0;

  cross_product_arbiter #(
    .NUM_REQ(N),
    .COORD_W(CW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_lock  (req_lock),
    .req_ref   (req_ref),
    .req_p1    (req_p1),
    .req_p2    (req_p2),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_result(rsp_result),
    .rsp_ge0   (rsp_ge0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic signed [RW-1:0] model_xprod(input point_t r, input point_t a, input point_t b);
    int dax, day, dbx, dby;
    dax = int'(a.x) - int'(r.x);
    day = int'(a.y) - int'(r.y);
    dbx = int'(b.x) - int'(r.x);
    dby = int'(b.y) - int'(r.y);
    return RW'(dax * dby - dbx * day);
  endfunction

  task automatic checkOutput(input string name, input logic signed [31:0] act, input logic signed [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic setOpHand(input int i, input point_t r, input point_t a, input point_t b,
                           input logic signed [RW-1:0] res);
    op_r[i]   = r;
    op_a[i]   = a;
    op_b[i]   = b;
    op_res[i] = res;
  endtask

  task automatic nextOp(input int i);
    op_seq++;
    op_r[i]   = {CW'((op_seq * 37 + 11) % 1024),  CW'((op_seq * 53 + 7) % 1024)};
    op_a[i]   = {CW'((op_seq * 101 + 3) % 1024),  CW'((op_seq * 17 + 900) % 1024)};
    op_b[i]   = {CW'((op_seq * 71 + 400) % 1024), CW'((op_seq * 29 + 250) % 1024)};
    op_res[i] = model_xprod(op_r[i], op_a[i], op_b[i]);
  endtask

  // One cycle: drive at the falling edge, check the grant, and record what the grant must return.
  task automatic applyStimulus(input logic rst, input logic [N-1:0] valid, input logic [N-1:0] lock,
                               input logic rdy, input int exp_grant);
    @(negedge clk);
    if (reset) exp_q.delete();
    reset     = rst;
    req_valid = valid;
    req_lock  = lock;
    rsp_ready = rdy;
    for (int i = 0; i < N; i++) begin
      req_ref[i*PT_W +: PT_W] = op_r[i];
      req_p1[i*PT_W +: PT_W]  = op_a[i];
      req_p2[i*PT_W +: PT_W]  = op_b[i];
    end
    #1;
    checkOutput("req_ready", req_ready, (exp_grant >= 0) ? (4'b0001 << exp_grant) : 4'b0000);
    if (exp_grant >= 0) begin
      exp_q.push_back('{id: 2'(exp_grant), res: op_res[exp_grant], ge0: (op_res[exp_grant] >= 0)});
      nextOp(exp_grant);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rsp_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("[TB] FAIL rsp_unexpected: actual=id %0d result %0d required=no response", rsp_id, rsp_result);
        end else begin
          e = exp_q[0];
          checkOutput("rsp_id", rsp_id, e.id);
          checkOutput("rsp_result", $signed(rsp_result), $signed(e.res));
          checkOutput("rsp_ge0", rsp_ge0, e.ge0);
          if (rsp_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    int rr_seq[6];
    rr_seq    = '{0, 1, 2, 3, 0, 1};
    reset     = 1'b1;
    req_valid = '0;
    req_lock  = '0;
    rsp_ready = 1'b0;
    req_ref   = '0;
    req_p1    = '0;
    req_p2    = '0;
    for (int i = 0; i < N; i++) nextOp(i);

    // Reset holds every output low even with all requests pending.
    applyStimulus(1'b1, 4'b1111, 4'b0000, 1'b1, -1);
    applyStimulus(1'b1, 4'b1111, 4'b0000, 1'b1, -1);
    checkOutput("rst_rsp_valid", rsp_valid, 0);
    checkOutput("rst_rsp_id", rsp_id, 0);
    checkOutput("rst_rsp_result", $signed(rsp_result), 0);
    checkOutput("rst_rsp_ge0", rsp_ge0, 0);

    for (int c = 0; c < 6; c++) applyStimulus(1'b0, 4'b1111, 4'b0000, 1'b1, rr_seq[c]);
    applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b1, -1);

    setOpHand(2, {10'd0, 10'd0}, {10'd10, 10'd0}, {10'd0, 10'd10}, 23'sd100);
    applyStimulus(1'b0, 4'b0100, 4'b0000, 1'b1, 2);
    for (int k = 1; k <= LAT; k++) begin
      applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b1, -1);
      checkOutput("latency_rsp_valid", rsp_valid, (k == LAT) ? 1 : 0);
    end

    setOpHand(3, {10'd1023, 10'd1023}, {10'd0, 10'd1023}, {10'd1023, 10'd0}, 23'sd1046529);
    setOpHand(0, {10'd1023, 10'd1023}, {10'd1023, 10'd0}, {10'd0, 10'd1023}, -23'sd1046529);
    setOpHand(1, {10'd5, 10'd5}, {10'd10, 10'd10}, {10'd20, 10'd20}, 23'sd0);
    applyStimulus(1'b0, 4'b1000, 4'b0000, 1'b1, 3);
    applyStimulus(1'b0, 4'b0001, 4'b0000, 1'b1, 0);
    applyStimulus(1'b0, 4'b0010, 4'b0000, 1'b1, 1);
    applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b1, -1);

    // Requester 2 owns the datapath across a dropped-valid gap, then round robin resumes at 3.
    applyStimulus(1'b0, 4'b1111, 4'b0100, 1'b1, 2);
    applyStimulus(1'b0, 4'b1111, 4'b0100, 1'b1, 2);
    applyStimulus(1'b0, 4'b1011, 4'b0100, 1'b1, -1);
    applyStimulus(1'b0, 4'b1111, 4'b0000, 1'b1, 2);
    applyStimulus(1'b0, 4'b1111, 4'b0000, 1'b1, 3);
    applyStimulus(1'b0, 4'b1111, 4'b0000, 1'b1, 0);
    applyStimulus(1'b0, 4'b1111, 4'b0000, 1'b1, 1);
    applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b1, -1);

    applyStimulus(1'b0, 4'b0100, 4'b0000, 1'b1, 2);
`ifdef CROSS_ARB_PIPE_EN
    applyStimulus(1'b0, 4'b0001, 4'b0000, 1'b0, 0);
`else
    applyStimulus(1'b0, 4'b0001, 4'b0000, 1'b0, -1);
`endif
    applyStimulus(1'b0, 4'b0001, 4'b0000, 1'b0, -1);
    applyStimulus(1'b0, 4'b0001, 4'b0000, 1'b0, -1);
    applyStimulus(1'b0, 4'b0001, 4'b0000, 1'b1, 0);
    applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b1, -1);
    applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b1, -1);

    applyStimulus(1'b0, 4'b1010, 4'b0000, 1'b1, 1);
`ifdef CROSS_ARB_PIPE_EN
    applyStimulus(1'b0, 4'b1000, 4'b0000, 1'b0, 3);
`else
    applyStimulus(1'b0, 4'b1000, 4'b0000, 1'b0, -1);
`endif
    applyStimulus(1'b1, 4'b1111, 4'b0000, 1'b0, -1);
    applyStimulus(1'b0, 4'b1110, 4'b0000, 1'b1, 1);
    checkOutput("post_rst_rsp_valid", rsp_valid, 0);

    repeat (4) applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b1, -1);
    checkOutput("drain_pending", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
